// File: rtl/seq_detect_rate_monitor.sv
// -----------------------------------------------------------------------------
// seq_detect_rate_monitor
//
// Counts pulses from the 0110 sequence detector over back-to-back windows of
// WINDOW_CYCLES clocks. At each window close it publishes the count with a
// one-cycle valid strobe and evaluates a rate alarm against a threshold. It
// also keeps a saturating lifetime total and a sticky overflow flag.
//
// Optional build macro: SEQ_MON_STICKY_ALARM_EN
//   undefined : alarm is re-evaluated at every window close; clear_alarm unused
//   defined   : alarm is sticky until clear_alarm or reset (a set wins a clash)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   enable       in   monitor run enable (level)
//   detected     in   detector output; each high cycle is one detection
//   threshold    in   [CNT_W] alarm threshold, 0 disables the alarm
//   clear_alarm  in   alarm clear (sticky-alarm build only)
//   count_out    out  [CNT_W] count of the last completed window
//   count_valid  out  one-cycle strobe when count_out updates
//   alarm        out  last closing count >= threshold
//   total_count  out  [TOT_W] saturating lifetime detection count
//   overflow     out  sticky: a window count or total_count saturated
// -----------------------------------------------------------------------------
module seq_detect_rate_monitor #(
  parameter int WINDOW_CYCLES = 64,
  parameter int CNT_W         = 8,
  parameter int TOT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             detected,
  input  logic [CNT_W-1:0] threshold,
  input  logic             clear_alarm,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             alarm,
  output logic [TOT_W-1:0] total_count,
  output logic             overflow
);

  localparam int TMR_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(WINDOW_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [TMR_W-1:0] timer_r;
  logic [CNT_W-1:0] acc_r;

  logic             active_s;
  logic             close_s;
  logic [CNT_W-1:0] acc_inc_s;
  logic [TOT_W-1:0] tot_inc_s;
  logic             sat_hit_s;
  logic             alarm_hit_s;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: enable is checked on every edge in both states
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_nxt_s = RUN;
        else        state_nxt_s = IDLE;
      end
      RUN: begin
        if (!enable) state_nxt_s = IDLE;
        else         state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output/datapath control decode
  always_comb begin
    active_s = 1'b0;
    case (state_r)
      IDLE:    active_s = 1'b0;
      // An edge in RUN with enable low only leaves RUN; the window is discarded.
      RUN:     active_s = enable;
      default: active_s = 1'b0;
    endcase

    close_s = active_s && (timer_r == LAST_TICK);

    // Saturating increments; the closing count includes the close-cycle pulse.
    if (detected && !(&acc_r)) acc_inc_s = acc_r + CNT_W'(1);
    else                       acc_inc_s = acc_r;

    if (detected && !(&total_count)) tot_inc_s = total_count + TOT_W'(1);
    else                             tot_inc_s = total_count;

    sat_hit_s   = active_s && detected && ((&acc_r) || (&total_count));
    alarm_hit_s = (threshold != {CNT_W{1'b0}}) && (acc_inc_s >= threshold);
  end

  // Window timer and per-window accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_r <= {TMR_W{1'b0}};
      acc_r   <= {CNT_W{1'b0}};
    end else if (!active_s || close_s) begin
      timer_r <= {TMR_W{1'b0}};
      acc_r   <= {CNT_W{1'b0}};
    end else begin
      timer_r <= timer_r + TMR_W'(1);
      acc_r   <= acc_inc_s;
    end
  end

  // Published window count and its one-cycle valid strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_out   <= {CNT_W{1'b0}};
      count_valid <= 1'b0;
    end else if (close_s) begin
      count_out   <= acc_inc_s;
      count_valid <= 1'b1;
    end else begin
      count_out   <= count_out;
      count_valid <= 1'b0;
    end
  end

  // Lifetime total and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_count <= {TOT_W{1'b0}};
      overflow    <= 1'b0;
    end else if (active_s) begin
      total_count <= tot_inc_s;
      overflow    <= overflow | sat_hit_s;
    end else begin
      total_count <= total_count;
      overflow    <= overflow;
    end
  end

`ifdef SEQ_MON_STICKY_ALARM_EN
  // Sticky alarm: a setting close beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm <= 1'b0;
    end else if (close_s && alarm_hit_s) begin
      alarm <= 1'b1;
    end else if (clear_alarm) begin
      alarm <= 1'b0;
    end else begin
      alarm <= alarm;
    end
  end
`else
  // clear_alarm has no function in this build
  logic unused_clear_s;
  assign unused_clear_s = clear_alarm;

  // Alarm re-evaluated at every window close, held in between
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm <= 1'b0;
    end else if (close_s) begin
      alarm <= alarm_hit_s;
    end else begin
      alarm <= alarm;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_rate_monitor.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_rate_monitor
//
// Directed bench for seq_detect_rate_monitor (WINDOW_CYCLES=16, CNT_W=4,
// TOT_W=6). A table of back-to-back windows (detection mask, threshold before
// and after mid-window, expected results) is applied in a loop, followed by
// hand-written sequences for async reset, enable drop, enable falling on the
// close edge and the clear_alarm/close collision.
// -----------------------------------------------------------------------------
module tb_seq_detect_rate_monitor;

  localparam int WC = 16;
  localparam int CW = 4;
  localparam int TW = 6;

`ifdef SEQ_MON_STICKY_ALARM_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          detected;
  logic [CW-1:0] threshold;
  logic          clear_alarm;
  logic [CW-1:0] count_out;
  logic          count_valid;
  logic          alarm;
  logic [TW-1:0] total_count;
  logic          overflow;

  seq_detect_rate_monitor #(
    .WINDOW_CYCLES(WC),
    .CNT_W        (CW),
    .TOT_W        (TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .detected   (detected),
    .threshold  (threshold),
    .clear_alarm(clear_alarm),
    .count_out  (count_out),
    .count_valid(count_valid),
    .alarm      (alarm),
    .total_count(total_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [15:0] mask;        // bit i = detected at window timer i
    logic [3:0]  thr_a;       // threshold during timer 0..7
    logic [3:0]  thr_b;       // threshold during timer 8..15 (sampled at close)
    int          exp_count;
    bit          exp_alarm;
    bit          exp_alarm_sticky;
    int          exp_total;
    bit          exp_ovf;
  } win_t;

  win_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0110 detector model: stream bit [15-i] is the input bit at cycle i,
  // mask bit i is high when the last four bits seen are 0110.
  function automatic logic [15:0] det_mask(input logic [15:0] stream);
    logic [3:0]  h = 4'b0000;
    logic [15:0] m = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      h    = {h[2:0], stream[15-i]};
      m[i] = (h == 4'b0110);
    end
    return m;
  endfunction

  initial begin
    int strobes;

    // mask, thr_a, thr_b, count, alarm, alarm_sticky, total, overflow
    tbl[0] = '{det_mask(16'b0110_0110_0110_0000), 4'd3, 4'd3, 3, 1'b1, 1'b1, 3, 1'b0};
    tbl[1] = '{16'h8020, 4'd3, 4'd3,  2, 1'b0, 1'b1,  5, 1'b0};  // pulse in close cycle
    tbl[2] = '{16'hFFFF, 4'd10, 4'd10, 15, 1'b1, 1'b1, 21, 1'b1}; // window saturates
    tbl[3] = '{16'h03FF, 4'd0, 4'd0, 10, 1'b0, 1'b1, 31, 1'b1};  // threshold 0
    tbl[4] = '{16'hFFFF, 4'd15, 4'd15, 15, 1'b1, 1'b1, 47, 1'b1};
    tbl[5] = '{16'hFFFF, 4'd15, 4'd15, 15, 1'b1, 1'b1, 63, 1'b1};
    tbl[6] = '{16'h000F, 4'd4, 4'd4,  4, 1'b1, 1'b1, 63, 1'b1};  // total saturated
    tbl[7] = '{16'h0F00, 4'd1, 4'd5,  4, 1'b0, 1'b1, 63, 1'b1};  // mid-window thr change

    reset       = 1'b1;
    enable      = 1'b0;
    detected    = 1'b0;
    threshold   = 4'd0;
    clear_alarm = 1'b0;
    step();
    step();
    check("rst_count_out",   count_out,   0);
    check("rst_count_valid", count_valid, 0);
    check("rst_alarm",       alarm,       0);
    check("rst_total",       total_count, 0);
    check("rst_overflow",    overflow,    0);

    reset  = 1'b0;
    enable = 1'b1;
    step();  // IDLE -> RUN; next edge is timer cycle 0

    // Table-driven back-to-back windows
    for (int w = 0; w < 8; w++) begin
      strobes = 0;
      for (int i = 0; i < WC; i++) begin
        detected  = tbl[w].mask[i];
        threshold = (i < 8) ? tbl[w].thr_a : tbl[w].thr_b;
        step();
        if (i < WC - 1 && count_valid !== 1'b0) strobes++;
      end
      check($sformatf("w%0d_early_strobe", w), strobes, 0);
      check($sformatf("w%0d_count_valid", w), count_valid, 1);
      check($sformatf("w%0d_count_out", w), count_out, tbl[w].exp_count);
      check($sformatf("w%0d_alarm", w), alarm,
            STICKY ? tbl[w].exp_alarm_sticky : tbl[w].exp_alarm);
      check($sformatf("w%0d_total", w), total_count, tbl[w].exp_total);
      check($sformatf("w%0d_overflow", w), overflow, tbl[w].exp_ovf);
    end

    // Strobe is one cycle wide, then async reset mid-window
    detected = 1'b0;
    step();
    check("strobe_width", count_valid, 0);
    step();
    step();
    #3;
    reset = 1'b1;
    #1;
    check("async_count_out",   count_out,   0);
    check("async_count_valid", count_valid, 0);
    check("async_alarm",       alarm,       0);
    check("async_total",       total_count, 0);
    check("async_overflow",    overflow,    0);
    #2;
    reset = 1'b0;

    // Enable drop at timer 8 after 2 detections
    threshold = 4'd3;
    strobes   = 0;
    step();  // IDLE -> RUN
    for (int i = 0; i < 8; i++) begin
      detected = (i == 2 || i == 5);
      step();
      if (count_valid !== 1'b0) strobes++;
    end
    enable   = 1'b0;
    detected = 1'b0;
    step();  // drop edge, window discarded
    if (count_valid !== 1'b0) strobes++;
    detected = 1'b1;  // must be ignored while idle
    for (int i = 0; i < 4; i++) begin
      step();
      if (count_valid !== 1'b0) strobes++;
    end
    check("idle_total_hold", total_count, 2);
    enable   = 1'b1;
    detected = 1'b0;
    step();  // re-enter RUN
    for (int i = 0; i < WC; i++) begin
      detected = (i == 3);
      step();
      if (i < WC - 1 && count_valid !== 1'b0) strobes++;
    end
    check("drop_no_strobe",   strobes,     0);
    check("drop_count_valid", count_valid, 1);
    check("drop_count_out",   count_out,   1);
    check("drop_total",       total_count, 3);
    check("drop_alarm",       alarm,       0);
    check("drop_overflow",    overflow,    0);

    // Enable falls on what would be the close edge
    strobes = 0;
    for (int i = 0; i < WC - 1; i++) begin
      detected = 1'b0;
      step();
      if (count_valid !== 1'b0) strobes++;
    end
    enable   = 1'b0;
    detected = 1'b1;
    step();
    if (count_valid !== 1'b0) strobes++;
    check("close_drop_no_strobe", strobes,   0);
    check("close_drop_count_out", count_out, 1);

    // clear_alarm on the same edge as a setting close, then a lone clear
    enable    = 1'b1;
    detected  = 1'b0;
    threshold = 4'd2;
    step();  // re-enter RUN
    for (int i = 0; i < WC; i++) begin
      detected    = (i == 4 || i == 9);
      clear_alarm = (i == WC - 1);
      step();
    end
    check("collide_count_valid", count_valid, 1);
    check("collide_count_out",   count_out,   2);
    check("collide_alarm",       alarm,       1);
    detected    = 1'b0;
    clear_alarm = 1'b1;
    step();
    clear_alarm = 1'b0;
    check("lone_clear_alarm", alarm, STICKY ? 0 : 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
